// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON types, constants and the single-round permutation p
package ascon_pack;

  localparam logic [63:0] ASCON128_IV    = 64'h80400c0600000000;
  localparam logic [3:0]  ROUND_PA_START = 4'd0;
  localparam logic [3:0]  ROUND_PB_START = 4'd6;
  localparam logic [3:0]  ROUND_LAST     = 4'd11;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD,
    ST_CT_WAIT,
    ST_PT_HOLD,
    ST_DATA_PERM,
    ST_FINAL,
    ST_DONE
  } dec_state_t;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One permutation round; the constant depends only on the absolute round index.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = {4'hf - r, r};
    x0 = s.x0;
    x1 = s.x1;
    x2 = s.x2 ^ {56'd0, c};
    x3 = s.x3;
    x4 = s.x4;
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    ascon_round.x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    ascon_round.x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    ascon_round.x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    ascon_round.x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    ascon_round.x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  endfunction

endpackage

// File: rtl/ascon_dec_fsm.sv
// rtl/ascon_dec_fsm.sv - decryption sequencer: phase FSM, round counter and block counter
module ascon_dec_fsm
  import ascon_pack::*;
#(
  parameter int NB_CT_BLOCKS = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_ct_valid,
  input  logic       i_pt_ready,
  output logic [3:0] o_round,
  output logic       o_load,
  output logic       o_perm,
  output logic       o_init_last,
  output logic       o_ad_first,
  output logic       o_ad_last,
  output logic       o_fin_first,
  output logic       o_fin_last,
  output logic       o_ct_accept,
  output logic       o_ct_ready,
  output logic       o_pt_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BW = (NB_CT_BLOCKS < 2) ? 1 : $clog2(NB_CT_BLOCKS + 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(NB_CT_BLOCKS);

  dec_state_t    r_state;
  logic [3:0]    r_round;
  logic [BW-1:0] r_blk;
  logic          r_ct_ready;
  logic          r_pt_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_last;

  assign w_last      = (r_round == ROUND_LAST);
  assign o_round     = r_round;
  assign o_load      = (r_state == ST_IDLE) && i_start;
  assign o_perm      = (r_state == ST_INIT) || (r_state == ST_AD) ||
                       (r_state == ST_DATA_PERM) || (r_state == ST_FINAL);
  assign o_init_last = (r_state == ST_INIT) && w_last;
  assign o_ad_first  = (r_state == ST_AD) && (r_round == ROUND_PB_START);
  assign o_ad_last   = (r_state == ST_AD) && w_last;
  assign o_fin_first = (r_state == ST_FINAL) && (r_round == ROUND_PA_START);
  assign o_fin_last  = (r_state == ST_FINAL) && w_last;
  assign o_ct_accept = (r_state == ST_CT_WAIT) && i_ct_valid;
  assign o_ct_ready  = r_ct_ready;
  assign o_pt_valid  = r_pt_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_round    <= 4'd0;
      r_blk      <= '0;
      r_ct_ready <= 1'b0;
      r_pt_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_INIT;
            r_round <= ROUND_PA_START;
            r_blk   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_INIT: begin
          if (w_last) begin
            r_state <= ST_AD;
            r_round <= ROUND_PB_START;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_AD: begin
          if (w_last) begin
            r_state    <= ST_CT_WAIT;
            r_ct_ready <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_CT_WAIT: begin
          if (i_ct_valid) begin
            r_state    <= ST_PT_HOLD;
            r_ct_ready <= 1'b0;
            r_pt_valid <= 1'b1;
            r_blk      <= r_blk + 1'b1;
          end
        end
        ST_PT_HOLD: begin
          if (i_pt_ready) begin
            r_pt_valid <= 1'b0;
            if (r_blk == BLK_LAST) begin
              r_state <= ST_FINAL;
              r_round <= ROUND_PA_START;
            end else begin
              r_state <= ST_DATA_PERM;
              r_round <= ROUND_PB_START;
            end
          end
        end
        ST_DATA_PERM: begin
          if (w_last) begin
            r_state    <= ST_CT_WAIT;
            r_ct_ready <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_FINAL: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ascon128_decrypt.sv
// rtl/ascon128_decrypt.sv - ASCON-128 decryption top: state, plaintext register, tag compare
// Optional: ASCON_DEC_ZEROIZE_EN clears state and pt_o in DONE when the tag mismatches.
module ascon128_decrypt
  import ascon_pack::*;
#(
  parameter int NB_CT_BLOCKS = 3
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [63:0]  ad_i,
  input  logic         ct_valid_i,
  input  logic [63:0]  ct_i,
  output logic         ct_ready_o,
  output logic         pt_valid_o,
  output logic [63:0]  pt_o,
  input  logic         pt_ready_i,
  input  logic [127:0] tag_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  type_state    r_state;
  logic [63:0]  r_pt;
  logic         r_tag_ok;

  logic [3:0]   w_round;
  logic         w_load, w_perm, w_init_last, w_ad_first, w_ad_last;
  logic         w_fin_first, w_fin_last, w_ct_accept, w_done;
  type_state    w_pre, w_rnd, w_post;
  logic [127:0] w_tag;

  ascon_dec_fsm #(
    .NB_CT_BLOCKS(NB_CT_BLOCKS)
  ) u_fsm (
    .i_clk       (clock_i),
    .i_rst       (resetb_i),
    .i_start     (start_i),
    .i_ct_valid  (ct_valid_i),
    .i_pt_ready  (pt_ready_i),
    .o_round     (w_round),
    .o_load      (w_load),
    .o_perm      (w_perm),
    .o_init_last (w_init_last),
    .o_ad_first  (w_ad_first),
    .o_ad_last   (w_ad_last),
    .o_fin_first (w_fin_first),
    .o_fin_last  (w_fin_last),
    .o_ct_accept (w_ct_accept),
    .o_ct_ready  (ct_ready_o),
    .o_pt_valid  (pt_valid_o),
    .o_busy      (busy_o),
    .o_done      (w_done)
  );

  // Key/AD injections wrap the round: some land before it, some after.
  always_comb begin
    w_pre = r_state;
    if (w_ad_first) w_pre.x0 = r_state.x0 ^ ad_i;
    if (w_fin_first) begin
      w_pre.x1 = r_state.x1 ^ key_i[127:64];
      w_pre.x2 = r_state.x2 ^ key_i[63:0];
    end
    w_rnd  = ascon_round(w_pre, w_round);
    w_post = w_rnd;
    if (w_init_last) begin
      w_post.x3 = w_rnd.x3 ^ key_i[127:64];
      w_post.x4 = w_rnd.x4 ^ key_i[63:0];
    end
    if (w_ad_last) w_post.x4 = w_rnd.x4 ^ 64'd1;
    w_tag = {w_rnd.x3, w_rnd.x4} ^ key_i;
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      r_state  <= '0;
      r_pt     <= '0;
      r_tag_ok <= 1'b0;
    end else begin
      if (w_load) begin
        r_state  <= {ASCON128_IV, key_i, nonce_i};
        r_tag_ok <= 1'b0;
      end else if (w_perm) begin
        r_state <= w_post;
        if (w_fin_last) r_tag_ok <= (w_tag == tag_i);
      end else if (w_ct_accept) begin
        r_pt       <= r_state.x0 ^ ct_i;
        r_state.x0 <= ct_i;
      end
`ifdef ASCON_DEC_ZEROIZE_EN
      else if (w_done && !r_tag_ok) begin
        r_state <= '0;
        r_pt    <= '0;
      end
`endif
    end
  end

  assign pt_o     = r_pt;
  assign done_o   = w_done;
  assign tag_ok_o = r_tag_ok;

endmodule

// File: tb/tb_ascon128_decrypt.sv
// tb/tb_ascon128_decrypt.sv - directed bench: ciphertext/tag from a bench-side ASCON encryption model
module tb_ascon128_decrypt;

  localparam int NB = 3;
  localparam logic [63:0]  M_IV  = 64'h80400c0600000000;
  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NONCE = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [63:0]  AD    = 64'h3230323280000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clock_i = 1'b0;
  logic         resetb_i, start_i, ct_valid_i, pt_ready_i;
  logic [127:0] key_i, nonce_i, tag_i;
  logic [63:0]  ad_i, ct_i;
  logic         ct_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o;
  logic [63:0]  pt_o;

  logic [63:0]  pt_v [NB];
  logic [63:0]  ct_v [NB];
  logic [127:0] tag_v;
  logic [63:0]  mx [5];
  int           n_checks = 0;
  int           n_err = 0;

  always #5 clock_i = ~clock_i;

  ascon128_decrypt #(.NB_CT_BLOCKS(NB)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i),
    .ct_valid_i(ct_valid_i), .ct_i(ct_i), .ct_ready_o(ct_ready_o),
    .pt_valid_o(pt_valid_o), .pt_o(pt_o), .pt_ready_i(pt_ready_i),
    .tag_i(tag_i), .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Column-wise S-box lookup, deliberately not the bitsliced form.
  task automatic m_perm(input int r0);
    for (int r = r0; r < 12; r++) begin
      logic [7:0] c;
      logic [4:0] v;
      c = 8'(((15 - r) << 4) | r);
      mx[2] = mx[2] ^ {56'd0, c};
      for (int j = 0; j < 64; j++) begin
        v = {mx[0][j], mx[1][j], mx[2][j], mx[3][j], mx[4][j]};
        v = SBOX[v];
        mx[0][j] = v[4]; mx[1][j] = v[3]; mx[2][j] = v[2]; mx[3][j] = v[1]; mx[4][j] = v[0];
      end
      mx[0] = mx[0] ^ rr(mx[0], 19) ^ rr(mx[0], 28);
      mx[1] = mx[1] ^ rr(mx[1], 61) ^ rr(mx[1], 39);
      mx[2] = mx[2] ^ rr(mx[2], 1)  ^ rr(mx[2], 6);
      mx[3] = mx[3] ^ rr(mx[3], 10) ^ rr(mx[3], 17);
      mx[4] = mx[4] ^ rr(mx[4], 7)  ^ rr(mx[4], 41);
    end
  endtask

  task automatic model_encrypt();
    mx[0] = M_IV; mx[1] = KEY[127:64]; mx[2] = KEY[63:0];
    mx[3] = NONCE[127:64]; mx[4] = NONCE[63:0];
    m_perm(0);
    mx[3] = mx[3] ^ KEY[127:64]; mx[4] = mx[4] ^ KEY[63:0];
    mx[0] = mx[0] ^ AD;
    m_perm(6);
    mx[4] = mx[4] ^ 64'd1;
    for (int i = 0; i < NB; i++) begin
      mx[0] = mx[0] ^ pt_v[i];
      ct_v[i] = mx[0];
      if (i < NB - 1) m_perm(6);
    end
    mx[1] = mx[1] ^ KEY[127:64]; mx[2] = mx[2] ^ KEY[63:0];
    m_perm(0);
    tag_v = {mx[3], mx[4]} ^ KEY;
  endtask

  // Cycle 0 is the cycle in which start_i is sampled in IDLE.
  task automatic run_msg(input string name, input bit flip, input int bp, input bit hold_start,
                         input bit ct_always, input int abort_cyc, input int exp_lat);
    int cyc = 0, nct = 0, npt = 0, ndone = 0, hold = 0, after = 0, lat = -1;
    bit seen = 0, stalled = 0;
    logic [63:0] prev_pt = '0;
    @(negedge clock_i);
    tag_i      = flip ? (tag_v ^ 128'd1) : tag_v;
    start_i    = 1'b1;
    pt_ready_i = (bp == 0);
    ct_valid_i = ct_always;
    ct_i       = ct_v[0];
    while (cyc < 400 && after < 4) begin
      @(negedge clock_i);
      cyc++;
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        resetb_i = 1'b0; start_i = 1'b0; ct_valid_i = 1'b0; pt_ready_i = 1'b0;
        check({name, "_rst_ct_ready"}, ct_ready_o, 0);
        check({name, "_rst_pt_valid"}, pt_valid_o, 0);
        check({name, "_rst_pt"}, pt_o, 0);
        check({name, "_rst_busy"}, busy_o, 0);
        check({name, "_rst_done"}, done_o, 0);
        check({name, "_rst_tag_ok"}, tag_ok_o, 0);
        return;
      end
      if (done_o) begin
        ndone++;
        if (!seen) begin
          lat = cyc;
          check({name, "_busy_at_done"}, busy_o, 0);
          check({name, "_tag_ok_at_done"}, tag_ok_o, !flip);
        end
        seen = 1;
      end
      if (seen) after++;
      start_i = hold_start && !seen;
      if (stalled) begin
        check({name, "_pt_valid_hold"}, pt_valid_o, 1);
        check({name, "_pt_stable"}, pt_o, prev_pt);
        check({name, "_ct_ready_in_hold"}, ct_ready_o, 0);
      end
      if (pt_valid_o) begin
        if (hold >= bp) begin
          pt_ready_i = 1'b1;
          if (npt < NB) check($sformatf("%s_pt%0d", name, npt), pt_o, pt_v[npt]);
          else check({name, "_pt_extra"}, npt, NB - 1);
          npt++; hold = 0; stalled = 0;
        end else begin
          pt_ready_i = 1'b0; hold++; stalled = 1; prev_pt = pt_o;
        end
      end else begin
        pt_ready_i = (bp == 0); stalled = 0;
      end
      if (nct < NB) ct_i = ct_v[nct];
      else ct_i = 64'hdeadbeefdeadbeef;
      ct_valid_i = ct_always ? 1'b1 : ct_ready_o;
      if (ct_valid_i && ct_ready_o) nct++;
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        check({name, "_blocks_before_rst"}, npt, 2);
        resetb_i = 1'b1;
      end
    end
    start_i = 1'b0; ct_valid_i = 1'b0;
    check({name, "_done_count"}, ndone, 1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_pt_count"}, npt, NB);
    check({name, "_ct_count"}, nct, NB);
    check({name, "_tag_ok_held"}, tag_ok_o, !flip);
    check({name, "_busy_idle"}, busy_o, 0);
`ifdef ASCON_DEC_ZEROIZE_EN
    check({name, "_pt_final"}, pt_o, flip ? 64'd0 : pt_v[NB-1]);
`else
    check({name, "_pt_final"}, pt_o, pt_v[NB-1]);
`endif
  endtask

  initial begin
    pt_v[0] = 64'h1111111111111111;
    pt_v[1] = 64'h2222222222222222;
    pt_v[2] = 64'h3333333333333333;
    model_encrypt();
    resetb_i = 1'b1; start_i = 1'b0; ct_valid_i = 1'b0; pt_ready_i = 1'b0;
    key_i = KEY; nonce_i = NONCE; ad_i = AD; ct_i = '0; tag_i = tag_v;
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b0;
    check("reset_ct_ready", ct_ready_o, 0);
    check("reset_pt_valid", pt_valid_o, 0);
    check("reset_pt", pt_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_tag_ok", tag_ok_o, 0);
    run_msg("roundtrip", 0, 0, 0, 0, 0, 49);
    run_msg("badtag",    1, 0, 0, 0, 0, 49);
    run_msg("backpres",  0, 5, 0, 0, 0, 64);
    run_msg("midreset",  0, 0, 0, 0, 31, 0);
    run_msg("afterrst",  0, 0, 0, 0, 0, 49);
    run_msg("holdstart", 0, 0, 1, 1, 0, 49);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
